// File: rtl/lut_table_loader.sv
// Coarse LUT loader: stores a 64-entry table streamed in over valid/ready and
// serves the registered entry[addr] / entry[addr+1] pair to the interpolator.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_EMPTY | no complete table held since reset; stream not accepted
// ST_LOAD  | accepting beats, entry load_count is written next
// ST_FULL  | complete table held, table_ready high, stream not accepted
module lut_table_loader #(
    parameter int ENTRIES = 64,
    parameter int AW      = 6,
    parameter int DW      = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_start,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data0,
    output logic [DW-1:0] rd_data1,
    output logic          table_ready,
    output logic          load_done,
    output logic [AW:0]   load_count
);

    localparam logic [AW:0] LAST_IDX = (AW+1)'(ENTRIES - 1);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [DW-1:0] r_mem [ENTRIES];
    logic [AW:0]   r_load_count;
    logic          r_load_done;
    logic [DW-1:0] r_rd_data0;
    logic [DW-1:0] r_rd_data1;
    logic          w_accept;
    logic          w_last;
    logic [AW-1:0] w_rd_addr_p1;

    // A restart request blocks the stream for its own cycle so the counter
    // reset and a write can never collide on the same edge.
    assign in_ready     = (r_state == ST_LOAD) && !load_start;
    assign w_accept     = in_valid && in_ready;
    assign w_last       = w_accept && (r_load_count == LAST_IDX);
    assign w_rd_addr_p1 = rd_addr + AW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (load_start) w_state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                if (load_start)  w_state_nxt = ST_LOAD;
                else if (w_last) w_state_nxt = ST_FULL;
            end
            ST_FULL: begin
                if (load_start) w_state_nxt = ST_LOAD;
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_load_count <= '0;
            r_load_done  <= 1'b0;
        end else begin
            r_load_done <= w_last;
            if (load_start) begin
                r_load_count <= '0;
            end else if (w_accept) begin
                r_load_count <= r_load_count + (AW+1)'(1);
            end
        end
    end

    // Table storage is deliberately not reset; validity is tracked by state.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_load_count[AW-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data0 <= '0;
            r_rd_data1 <= '0;
        end else begin
            r_rd_data0 <= r_mem[rd_addr];
            r_rd_data1 <= r_mem[w_rd_addr_p1];
        end
    end

    assign rd_data0    = r_rd_data0;
    assign rd_data1    = r_rd_data1;
    assign table_ready = (r_state == ST_FULL);
    assign load_done   = r_load_done;
    assign load_count  = r_load_count;

endmodule

// File: tb/tb_lut_table_loader.sv
// Bench for lut_table_loader: cycle model with a read scoreboard, a table of
// read vectors, and hand-written restart / async-reset / reload sequences.
module tb_lut_table_loader;

    localparam int M_EMPTY = 0;
    localparam int M_LOAD  = 1;
    localparam int M_FULL  = 2;

    logic       clk;
    logic       rst;
    logic       load_start;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] rd_addr;
    logic [7:0] rd_data0;
    logic [7:0] rd_data1;
    logic       table_ready;
    logic       load_done;
    logic [6:0] load_count;

    lut_table_loader #(.ENTRIES(64), .AW(6), .DW(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .load_start  (load_start),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .rd_addr     (rd_addr),
        .rd_data0    (rd_data0),
        .rd_data1    (rd_data1),
        .table_ready (table_ready),
        .load_done   (load_done),
        .load_count  (load_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       chk;
        logic [7:0] d0;
        logic [7:0] d1;
    } rd_exp_t;

    typedef struct {
        int         grp;
        logic [5:0] addr;
        logic [7:0] d0;
        logic [7:0] d1;
    } vec_t;

    rd_exp_t    rdq[$];
    vec_t       vecs[8];
    logic [7:0] m_mem[64];
    int         m_state;
    int         m_count;
    int         m_done;
    int         n_checks;
    int         n_fail;
    int         cnt_rdy;
    int         cnt_done;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] pat(input int kind, input int i);
        case (kind)
            0:       return 8'((i * 4) & 255);
            1:       return 8'(255 - i);
            2:       return 8'((i * 7 + 3) & 255);
            3:       return 8'((i * 3 + 1) & 255);
            default: return 8'((100 + i) & 255);
        endcase
    endfunction

    task automatic model_reset();
        m_state = M_EMPTY;
        m_count = 0;
        m_done  = 0;
        rdq.delete();
    endtask

    // One clock cycle: inputs are already applied by the caller.
    task automatic step();
        logic    exp_rdy;
        logic    acc;
        rd_exp_t e;
        rd_exp_t got;
        #2;
        exp_rdy = (m_state == M_LOAD) && !load_start && !rst;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        if (in_ready) cnt_rdy++;
        acc   = exp_rdy && in_valid;
        e.chk = (m_state == M_FULL) && !rst;
        e.d0  = m_mem[rd_addr];
        e.d1  = m_mem[(int'(rd_addr) + 1) % 64];
        rdq.push_back(e);
        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
        end else begin
            m_done = 0;
            if (load_start) begin
                m_state = M_LOAD;
                m_count = 0;
            end else if (acc) begin
                m_mem[m_count] = in_data;
                m_count++;
                if (m_count == 64) begin
                    m_state = M_FULL;
                    m_done  = 1;
                end
            end
        end
        if (load_done) cnt_done++;
        if (rdq.size() > 0) begin
            got = rdq.pop_front();
            if (got.chk) begin
                chk("sb_rd_data0", 32'(rd_data0), 32'(got.d0));
                chk("sb_rd_data1", 32'(rd_data1), 32'(got.d1));
            end
        end
        chk("load_count", 32'(load_count), 32'(m_count));
        chk("table_ready", 32'(table_ready), 32'(m_state == M_FULL));
        chk("load_done", 32'(load_done), 32'(m_done));
    endtask

    task automatic load_full(input int kind);
        load_start = 1'b1;
        in_valid   = 1'b0;
        step();
        load_start = 1'b0;
        in_valid   = 1'b1;
        for (int i = 0; i < 64; i++) begin
            in_data = pat(kind, i);
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic run_vecs(input int g);
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].grp == g) begin
                rd_addr = vecs[i].addr;
                step();
                chk("vec_rd_data0", 32'(rd_data0), 32'(vecs[i].d0));
                chk("vec_rd_data1", 32'(rd_data1), 32'(vecs[i].d1));
            end
        end
    endtask

    initial begin
        vecs[0] = '{grp: 0, addr: 6'd10, d0: 8'd40,  d1: 8'd44};
        vecs[1] = '{grp: 0, addr: 6'd63, d0: 8'd252, d1: 8'd0};
        vecs[2] = '{grp: 0, addr: 6'd0,  d0: 8'd0,   d1: 8'd4};
        vecs[3] = '{grp: 0, addr: 6'd31, d0: 8'd124, d1: 8'd128};
        vecs[4] = '{grp: 0, addr: 6'd62, d0: 8'd248, d1: 8'd252};
        vecs[5] = '{grp: 1, addr: 6'd0,  d0: 8'd255, d1: 8'd254};
        vecs[6] = '{grp: 1, addr: 6'd63, d0: 8'd192, d1: 8'd255};
        vecs[7] = '{grp: 1, addr: 6'd32, d0: 8'd223, d1: 8'd222};

        n_checks   = 0;
        n_fail     = 0;
        cnt_rdy    = 0;
        cnt_done   = 0;
        rst        = 1'b0;
        load_start = 1'b0;
        in_valid   = 1'b0;
        in_data    = 8'd0;
        rd_addr    = 6'd0;
        for (int i = 0; i < 64; i++) m_mem[i] = 8'd0;
        model_reset();

        // Reset state
        #1 rst = 1'b1;
        #2;
        chk("rst_load_count", 32'(load_count), 32'd0);
        chk("rst_table_ready", 32'(table_ready), 32'd0);
        chk("rst_load_done", 32'(load_done), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_rd_data0", 32'(rd_data0), 32'd0);
        chk("rst_rd_data1", 32'(rd_data1), 32'd0);
        step();
        step();
        rst = 1'b0;
        step();

        // First load of i*4, counting ready cycles and done pulses
        cnt_rdy  = 0;
        cnt_done = 0;
        load_full(0);
        step();
        step();
        chk("load1_ready_cycles", 32'(cnt_rdy), 32'd64);
        chk("load1_done_pulses", 32'(cnt_done), 32'd1);
        chk("load1_count", 32'(load_count), 32'd64);
        run_vecs(0);

        // Load with random in_valid gaps
        cnt_done   = 0;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        for (int c = 0; c < 1000 && m_count < 64; c++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = pat(2, m_count);
            step();
        end
        in_valid = 1'b0;
        step();
        chk("gap_count", 32'(load_count), 32'd64);
        chk("gap_done_pulses", 32'(cnt_done), 32'd1);
        for (int a = 0; a < 64; a++) begin
            rd_addr = 6'(a);
            step();
            chk("gap_contents", 32'(rd_data0), 32'(pat(2, a)));
        end

        // Restart after 20 beats; the beat offered with load_start is dropped
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        in_valid   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_data = pat(4, i);
            step();
        end
        chk("restart_mid_count", 32'(load_count), 32'd20);
        load_start = 1'b1;
        in_data    = 8'hAA;
        step();
        chk("restart_count_zero", 32'(load_count), 32'd0);
        load_start = 1'b0;
        cnt_done   = 0;
        for (int i = 0; i < 64; i++) begin
            in_data = pat(1, i);
            step();
        end
        in_valid = 1'b0;
        chk("restart_done_pulses", 32'(cnt_done), 32'd1);
        run_vecs(1);

        // Async reset at beat 30 takes effect without a clock edge
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        in_valid   = 1'b1;
        for (int i = 0; i < 30; i++) begin
            in_data = pat(4, i);
            step();
        end
        #2 rst = 1'b1;
        #1;
        chk("arst_load_count", 32'(load_count), 32'd0);
        chk("arst_table_ready", 32'(table_ready), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd0);
        chk("arst_rd_data0", 32'(rd_data0), 32'd0);
        chk("arst_rd_data1", 32'(rd_data1), 32'd0);
        chk("arst_load_done", 32'(load_done), 32'd0);
        model_reset();
        in_valid = 1'b0;
        step();
        rst = 1'b0;
        step();
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        load_full(0);
        step();
        chk("recover_count", 32'(load_count), 32'd64);
        run_vecs(0);

        // Reload from FULL with a read-before-write probe on entry 5
        load_start = 1'b1;
        step();
        chk("reload_ready_drop", 32'(table_ready), 32'd0);
        load_start = 1'b0;
        in_valid   = 1'b1;
        for (int i = 0; i < 64; i++) begin
            in_data = pat(3, i);
            rd_addr = (i == 5) ? 6'd5 : 6'd0;
            step();
            if (i == 5) begin
                chk("rbw_old_entry5", 32'(rd_data0), 32'd20);
                chk("rbw_old_entry6", 32'(rd_data1), 32'd24);
            end
        end
        in_valid = 1'b0;
        rd_addr  = 6'd5;
        step();
        chk("reload_new_entry5", 32'(rd_data0), 32'd16);
        chk("reload_new_entry6", 32'(rd_data1), 32'd19);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
